// File: rtl/poly_byte_decode_pkg.sv
// Shared ML-KEM types for the polynomial byte decoder.
//   ML_KEM_Q    : modulus q = 3329
//   ML_KEM_N    : coefficients per polynomial (256)
//   coef_t      : 12-bit coefficient
//   dec_state_e : decoder FSM state
package poly_byte_decode_pkg;
  localparam int ML_KEM_Q = 3329;
  localparam int ML_KEM_N = 256;

  typedef logic [11:0] coef_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dec_state_e;
endpackage

// File: rtl/poly_byte_decode_cond_sub_q.sv
// cond_sub_q: single conditional subtraction of q.
//   x_i    in  12  raw coefficient
//   y_o    out 12  x_i >= q ? x_i - q : x_i
//   ge_q_o out 1   x_i >= q
// One subtraction is enough because a 12-bit value is below 2q.
module cond_sub_q
  import poly_byte_decode_pkg::*;
(
  input  logic [11:0] x_i,
  output logic [11:0] y_o,
  output logic        ge_q_o
);
  assign ge_q_o = (x_i >= coef_t'(ML_KEM_Q));
  assign y_o    = ge_q_o ? (x_i - coef_t'(ML_KEM_Q)) : x_i;
endmodule

// File: rtl/poly_byte_decode.sv
// poly_byte_decode: streaming ByteDecode_D unpacker.
// Takes one 256-coefficient polynomial as 4*D little-endian 64-bit words and
// emits D-bit coefficients in index order, up to one per cycle.
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   run_i                   start one polynomial (sampled in IDLE)
//   din_i/din_vld_i/din_rdy_o     packed word stream
//   coef_o/idx_o/coef_vld_o/coef_rdy_i  coefficient stream (coef zero-extended)
//   busy_o                  high in RUN
//   done_o                  one-cycle pulse after the last coefficient
//   err_o                   sticky "coefficient >= q" flag (D=12)
// Build option: POLY_BYTE_DECODE_MODQ_CHECK_EN enables err_o; otherwise err_o
// stays 0. The mod-q reduction of coef_o for D=12 is always performed.
module poly_byte_decode
  import poly_byte_decode_pkg::*;
#(
  parameter int D = 12
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        run_i,
  input  logic [63:0] din_i,
  input  logic        din_vld_i,
  output logic        din_rdy_o,
  output logic [11:0] coef_o,
  output logic        coef_vld_o,
  input  logic        coef_rdy_i,
  output logic [7:0]  idx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  // Load only below 2*D bits, so fill peaks at 2*D-1+64.
  localparam int BUF_W = 64 + 2*D - 1;
  localparam int FW    = $clog2(BUF_W + 1);
  localparam int NW    = 4*D;
  localparam int WW    = $clog2(NW + 1);

  localparam logic [FW-1:0] D_F   = FW'(D);
  localparam logic [FW-1:0] TWO_D = FW'(2*D);
  localparam logic [FW-1:0] W64   = FW'(64);
  localparam logic [WW-1:0] NW_W  = WW'(NW);

`ifdef POLY_BYTE_DECODE_MODQ_CHECK_EN
  localparam logic ERR_EN = (D == 12);
`else
  localparam logic ERR_EN = 1'b0;
`endif

  dec_state_e       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [7:0]       idx_q, idx_d;
  logic             err_q, err_d;

  logic             run_st, load, take, ge_q;
  logic [11:0]      raw, red;
  logic [BUF_W-1:0] shifted, wmask, wdat;
  logic [FW-1:0]    pos;

  assign run_st     = (state_q == ST_RUN);
  assign din_rdy_o  = run_st && (wcnt_q < NW_W) && (fill_q < TWO_D);
  assign coef_vld_o = run_st && (fill_q >= D_F);
  assign load       = din_vld_i && din_rdy_o;
  assign take       = coef_vld_o && coef_rdy_i;

  assign raw = coef_t'(buf_q[D-1:0]);

  cond_sub_q u_csub (
    .x_i    (raw),
    .y_o    (red),
    .ge_q_o (ge_q)
  );

  assign coef_o = (D == 12) ? red : raw;
  assign idx_o  = idx_q;
  assign busy_o = run_st;
  assign done_o = (state_q == ST_DONE);
  assign err_o  = err_q;

  // A concurrent consume shifts first, so the new word lands at fill-D.
  // Bits above fill are always zero, so the mask only guards the window.
  assign shifted = take ? (buf_q >> D) : buf_q;
  assign pos     = take ? (fill_q - D_F) : fill_q;
  assign wmask   = {{(BUF_W-64){1'b0}}, {64{1'b1}}} << pos;
  assign wdat    = {{(BUF_W-64){1'b0}}, din_i} << pos;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (run_i) begin
          state_d = ST_RUN;
          buf_d   = '0;
          fill_d  = '0;
          wcnt_d  = '0;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        buf_d  = load ? ((shifted & ~wmask) | wdat) : shifted;
        fill_d = fill_q + (load ? W64 : '0) - (take ? D_F : '0);
        if (load) wcnt_d = wcnt_q + 1'b1;
        if (take) begin
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'(ML_KEM_N - 1)) state_d = ST_DONE;
        end
        err_d = err_q | (ERR_EN & take & ge_q);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      fill_q  <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end
endmodule
